id_ex_stage: RTL and testbench

ID/EX pipeline register and operand-forwarding front end of the execute stage. It latches decoded instruction state from ID and resolves RAW hazards by forwarding from EX/MEM and MEM/WB. It drives the ALU operands and 4-bit ALU control directly, and passes memory/write-back control and store data downstream. It also detects load-use hazards, inserts the required bubble, and tells IF/ID to hold.

---
 rtl/pipeline_pkg.sv | 45 ++++
 rtl/forward_unit.sv | 22 ++
 rtl/id_ex_stage.sv | 110 +++++++++++
 tb/tb_id_ex_stage.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared ALU/operand-select encodings and the ID/EX register bundle.
package pipeline_pkg;
    localparam int XLEN = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_XOR  = 4'b0011,
        ALU_SLL  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_SRA  = 4'b0110,
        ALU_SUB  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001,
        ALU_LUI  = 4'b1010
    } alu_op_e;

    typedef enum logic [1:0] {
        OPA_RS1  = 2'd0,
        OPA_PC   = 2'd1,
        OPA_ZERO = 2'd2
    } op_a_sel_e;

    typedef struct packed {
        logic                  valid;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  mem_to_reg;
        logic [REG_ADDR_W-1:0] rd_addr;
        logic [REG_ADDR_W-1:0] rs1_addr;
        logic [REG_ADDR_W-1:0] rs2_addr;
        logic [3:0]            alu_control;
        logic [1:0]            op_a_sel;
        logic                  alu_src;
        logic [XLEN-1:0]       pc;
        logic [XLEN-1:0]       rs1_data;
        logic [XLEN-1:0]       rs2_data;
        logic [XLEN-1:0]       imm;
    } id_ex_t;

    localparam id_ex_t BUBBLE = '0;
endpackage

// File: rtl/forward_unit.sv
// forward_unit: picks EX/MEM, then MEM/WB, then register-file data for one source operand.
module forward_unit #(
    parameter int W = 32,
    parameter int A = 5
) (
    input  logic [A-1:0] rs_addr,
    input  logic [W-1:0] rs_data,
    input  logic         exm_reg_write,
    input  logic [A-1:0] exm_rd,
    input  logic [W-1:0] exm_result,
    input  logic         mwb_reg_write,
    input  logic [A-1:0] mwb_rd,
    input  logic [W-1:0] mwb_result,
    output logic [W-1:0] fwd_data
);
    logic exm_hit, mwb_hit;

    // x0 is never forwarded; the register file already returns zero for it
    assign exm_hit = exm_reg_write && exm_rd != '0 && exm_rd == rs_addr;
    assign mwb_hit = mwb_reg_write && mwb_rd != '0 && mwb_rd == rs_addr;
    assign fwd_data = exm_hit ? exm_result : mwb_hit ? mwb_result : rs_data;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand forwarding and load-use hazard bubbling.
module id_ex_stage
    import pipeline_pkg::*;
#(
    parameter int REG_WIDTH  = XLEN,
    parameter int ADDR_WIDTH = REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_WIDTH-1:0]  id_pc,
    input  logic [REG_WIDTH-1:0]  id_rs1_data,
    input  logic [REG_WIDTH-1:0]  id_rs2_data,
    input  logic [REG_WIDTH-1:0]  id_imm,
    input  logic [ADDR_WIDTH-1:0] id_rs1_addr,
    input  logic [ADDR_WIDTH-1:0] id_rs2_addr,
    input  logic [ADDR_WIDTH-1:0] id_rd_addr,
    input  logic [3:0]            id_alu_control,
    input  logic [1:0]            id_op_a_sel,
    input  logic                  id_alu_src,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  id_mem_to_reg,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  exm_reg_write,
    input  logic [ADDR_WIDTH-1:0] exm_rd,
    input  logic [REG_WIDTH-1:0]  exm_result,
    input  logic                  mwb_reg_write,
    input  logic [ADDR_WIDTH-1:0] mwb_rd,
    input  logic [REG_WIDTH-1:0]  mwb_result,
    output logic [REG_WIDTH-1:0]  alu_in1,
    output logic [REG_WIDTH-1:0]  alu_in2,
    output logic [3:0]            alu_control,
    output logic                  ex_valid,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_mem_to_reg,
    output logic [ADDR_WIDTH-1:0] ex_rd_addr,
    output logic [REG_WIDTH-1:0]  ex_pc,
    output logic [REG_WIDTH-1:0]  ex_store_data,
    output logic                  load_use_hold
);
    id_ex_t r, nxt;
    logic [REG_WIDTH-1:0] fwd_rs1, fwd_rs2;

    always_comb begin
        nxt             = BUBBLE;
        nxt.valid       = id_valid;
        nxt.reg_write   = id_valid & id_reg_write;
        nxt.mem_read    = id_valid & id_mem_read;
        nxt.mem_write   = id_valid & id_mem_write;
        nxt.mem_to_reg  = id_valid & id_mem_to_reg;
        nxt.rd_addr     = id_rd_addr;
        nxt.rs1_addr    = id_rs1_addr;
        nxt.rs2_addr    = id_rs2_addr;
        nxt.alu_control = id_alu_control;
        nxt.op_a_sel    = id_op_a_sel;
        nxt.alu_src     = id_alu_src;
        nxt.pc          = id_pc;
        nxt.rs1_data    = id_rs1_data;
        nxt.rs2_data    = id_rs2_data;
        nxt.imm         = id_imm;
    end

    // a redirect kills the instruction anyway, so no need to hold upstream for it
    assign load_use_hold = !flush && r.valid && r.mem_read && r.rd_addr != '0 && id_valid &&
                           (r.rd_addr == id_rs1_addr || r.rd_addr == id_rs2_addr);

    always_ff @(posedge clk) begin
        if (!rst_n)
            r <= BUBBLE;
        else if (flush)
            r <= BUBBLE;
        else if (stall)
            r <= r;
        else if (load_use_hold)
            r <= BUBBLE;
        else
            r <= nxt;
    end

    forward_unit #(.W(REG_WIDTH), .A(ADDR_WIDTH)) u_fwd_rs1 (
        .rs_addr(r.rs1_addr), .rs_data(r.rs1_data),
        .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
        .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_result(mwb_result),
        .fwd_data(fwd_rs1)
    );

    forward_unit #(.W(REG_WIDTH), .A(ADDR_WIDTH)) u_fwd_rs2 (
        .rs_addr(r.rs2_addr), .rs_data(r.rs2_data),
        .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
        .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_result(mwb_result),
        .fwd_data(fwd_rs2)
    );

    assign alu_in1       = r.op_a_sel == OPA_RS1 ? fwd_rs1 : r.op_a_sel == OPA_PC ? r.pc : '0;
    assign alu_in2       = r.alu_src ? r.imm : fwd_rs2;
    assign ex_store_data = fwd_rs2;
    assign alu_control   = r.alu_control;
    assign ex_valid      = r.valid;
    assign ex_reg_write  = r.reg_write;
    assign ex_mem_read   = r.mem_read;
    assign ex_mem_write  = r.mem_write;
    assign ex_mem_to_reg = r.mem_to_reg;
    assign ex_rd_addr    = r.rd_addr;
    assign ex_pc         = r.pc;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed checks of capture, forwarding, load-use bubbling, stall/flush and reset.
module tb_id_ex_stage;
    logic        clk = 0;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [3:0]  id_alu_control;
    logic [1:0]  id_op_a_sel;
    logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        stall, flush;
    logic        exm_reg_write, mwb_reg_write;
    logic [4:0]  exm_rd, mwb_rd;
    logic [31:0] exm_result, mwb_result;
    logic [31:0] alu_in1, alu_in2, ex_pc, ex_store_data;
    logic [3:0]  alu_control;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic [4:0]  ex_rd_addr;
    logic        load_use_hold;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_alu_control(id_alu_control), .id_op_a_sel(id_op_a_sel), .id_alu_src(id_alu_src),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_mem_to_reg(id_mem_to_reg), .stall(stall), .flush(flush),
        .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
        .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_result(mwb_result),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_control(alu_control),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_rd_addr(ex_rd_addr),
        .ex_pc(ex_pc), .ex_store_data(ex_store_data), .load_use_hold(load_use_hold)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_valid = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
        id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0; id_alu_control = 0;
        id_op_a_sel = 0; id_alu_src = 0; id_reg_write = 0; id_mem_read = 0;
        id_mem_write = 0; id_mem_to_reg = 0; stall = 0; flush = 0;
        exm_reg_write = 0; exm_rd = 0; exm_result = 0;
        mwb_reg_write = 0; mwb_rd = 0; mwb_result = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        id_valid = 1; id_pc = 32'h100; id_rs1_addr = 3; id_rs1_data = 5;
        id_rs2_addr = 4; id_rs2_data = 9; id_rd_addr = 6; id_reg_write = 1;
        id_alu_control = 4'b0010;
        step();
        step();
        checks++;
        if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl got %b want 00000",
                {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg});
        end
        checks++;
        if ({alu_in1, alu_in2, ex_pc, ex_store_data} !== 128'h0) begin
            errors++; $display("FAIL reset_data got %h %h %h %h want 0", alu_in1, alu_in2, ex_pc, ex_store_data);
        end
        checks++;
        if (alu_control !== 4'h0 || ex_rd_addr !== 5'h0 || load_use_hold !== 1'b0) begin
            errors++; $display("FAIL reset_misc got alu_control=%h rd=%0d hold=%b want 0",
                alu_control, ex_rd_addr, load_use_hold);
        end
        rst_n = 1;
        step();
        checks++;
        if (ex_valid !== 1'b1 || ex_pc !== 32'h100 || alu_control !== 4'b0010 || ex_rd_addr !== 5'd6) begin
            errors++; $display("FAIL first_capture got valid=%b pc=%h alu=%h rd=%0d want 1 100 2 6",
                ex_valid, ex_pc, alu_control, ex_rd_addr);
        end
        checks++;
        if (alu_in1 !== 32'd5 || alu_in2 !== 32'd9 || ex_store_data !== 32'd9) begin
            errors++; $display("FAIL first_operands got %h %h %h want 5 9 9", alu_in1, alu_in2, ex_store_data);
        end
    endtask

    task automatic test_forward();
        clear_inputs();
        id_valid = 1; id_rs1_addr = 5; id_rs2_addr = 6; id_rs1_data = 32'hAAA;
        id_rs2_data = 32'hBBB; id_rd_addr = 8; id_reg_write = 1; id_alu_control = 4'b0010;
        step();
        id_valid = 0;
        exm_reg_write = 1; exm_rd = 5; exm_result = 32'h11;
        #1;
        checks++;
        if (alu_in1 !== 32'h11 || alu_in2 !== 32'hBBB) begin
            errors++; $display("FAIL exm_fwd got %h %h want 11 bbb", alu_in1, alu_in2);
        end
        mwb_reg_write = 1; mwb_rd = 5; mwb_result = 32'h22;
        #1;
        checks++;
        if (alu_in1 !== 32'h11) begin
            errors++; $display("FAIL exm_priority got %h want 11", alu_in1);
        end
        exm_reg_write = 0;
        #1;
        checks++;
        if (alu_in1 !== 32'h22) begin
            errors++; $display("FAIL mwb_fwd got %h want 22", alu_in1);
        end
        mwb_rd = 6;
        #1;
        checks++;
        if (alu_in1 !== 32'hAAA || alu_in2 !== 32'h22 || ex_store_data !== 32'h22) begin
            errors++; $display("FAIL mwb_fwd_rs2 got %h %h %h want aaa 22 22", alu_in1, alu_in2, ex_store_data);
        end
    endtask

    task automatic test_x0_guard();
        clear_inputs();
        id_valid = 1; id_rs1_addr = 0; id_rs1_data = 0; id_rs2_addr = 0; id_rd_addr = 1;
        step();
        id_valid = 0;
        exm_reg_write = 1; exm_rd = 0; exm_result = 32'hDEAD;
        mwb_reg_write = 1; mwb_rd = 0; mwb_result = 32'hBEEF;
        #1;
        checks++;
        if (alu_in1 !== 32'h0 || ex_store_data !== 32'h0) begin
            errors++; $display("FAIL x0_guard got %h %h want 0 0", alu_in1, ex_store_data);
        end
    endtask

    task automatic test_load_use();
        clear_inputs();
        id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_mem_to_reg = 1; id_rd_addr = 7;
        id_rs1_addr = 2; id_rs1_data = 32'h40; id_imm = 4; id_alu_src = 1; id_alu_control = 4'b0010;
        step();
        checks++;
        if (ex_mem_read !== 1'b1 || alu_in1 !== 32'h40 || alu_in2 !== 32'h4) begin
            errors++; $display("FAIL load_capture got mr=%b %h %h want 1 40 4", ex_mem_read, alu_in1, alu_in2);
        end
        id_mem_read = 0; id_mem_to_reg = 0; id_alu_src = 0; id_rd_addr = 8;
        id_rs1_addr = 3; id_rs1_data = 32'h3; id_rs2_addr = 7; id_rs2_data = 32'h0;
        id_imm = 0; id_pc = 32'h200;
        flush = 1;
        #1;
        checks++;
        if (load_use_hold !== 1'b0) begin
            errors++; $display("FAIL hold_flush_suppress got %b want 0", load_use_hold);
        end
        flush = 0;
        #1;
        checks++;
        if (load_use_hold !== 1'b1) begin
            errors++; $display("FAIL load_use_hold got %b want 1", load_use_hold);
        end
        step();
        checks++;
        if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || alu_control !== 4'h0 || ex_rd_addr !== 5'd0 || load_use_hold !== 1'b0) begin
            errors++; $display("FAIL load_use_bubble got v=%b rw=%b alu=%h rd=%0d hold=%b want 0 0 0 0 0",
                ex_valid, ex_reg_write, alu_control, ex_rd_addr, load_use_hold);
        end
        mwb_reg_write = 1; mwb_rd = 7; mwb_result = 32'h1234;
        step();
        checks++;
        if (ex_valid !== 1'b1 || ex_pc !== 32'h200 || alu_in2 !== 32'h1234 || ex_store_data !== 32'h1234 || alu_in1 !== 32'h3) begin
            errors++; $display("FAIL load_use_consumer got v=%b pc=%h in1=%h in2=%h sd=%h want 1 200 3 1234 1234",
                ex_valid, ex_pc, alu_in1, alu_in2, ex_store_data);
        end
        checks++;
        if (load_use_hold !== 1'b0) begin
            errors++; $display("FAIL load_use_clear got %b want 0", load_use_hold);
        end
        id_valid = 0;
    endtask

    task automatic test_stall_flush();
        clear_inputs();
        id_valid = 1; id_pc = 32'h300; id_reg_write = 1; id_alu_control = 4'b0111;
        id_rs1_addr = 9; id_rs1_data = 32'h99; id_rd_addr = 10;
        step();
        id_pc = 32'h400; id_alu_control = 4'b0001; id_rs1_data = 32'h55; id_rd_addr = 11;
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (ex_valid !== 1'b1 || ex_pc !== 32'h300 || alu_control !== 4'b0111 || alu_in1 !== 32'h99 || ex_rd_addr !== 5'd10) begin
                errors++; $display("FAIL stall_hold[%0d] got v=%b pc=%h alu=%h in1=%h rd=%0d want 1 300 7 99 10",
                    i, ex_valid, ex_pc, alu_control, alu_in1, ex_rd_addr);
            end
        end
        flush = 1;
        step();
        checks++;
        if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || alu_control !== 4'h0) begin
            errors++; $display("FAIL flush_over_stall got v=%b rw=%b alu=%h want 0 0 0", ex_valid, ex_reg_write, alu_control);
        end
        clear_inputs();
        id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_rd_addr = 12; id_pc = 32'h500;
        step();
        id_mem_read = 0; id_rd_addr = 13; id_rs1_addr = 12; id_pc = 32'h504;
        stall = 1;
        step();
        checks++;
        if (load_use_hold !== 1'b1 || ex_mem_read !== 1'b1 || ex_pc !== 32'h500) begin
            errors++; $display("FAIL stall_load_use got hold=%b mr=%b pc=%h want 1 1 500", load_use_hold, ex_mem_read, ex_pc);
        end
        rst_n = 0;
        step();
        rst_n = 1;
        checks++;
        if (ex_valid !== 1'b0 || ex_pc !== 32'h0 || ex_mem_read !== 1'b0) begin
            errors++; $display("FAIL reset_mid_stall got v=%b pc=%h mr=%b want 0 0 0", ex_valid, ex_pc, ex_mem_read);
        end
        stall = 0;
    endtask

    task automatic test_lui();
        clear_inputs();
        id_valid = 1; id_op_a_sel = 2; id_alu_src = 1; id_imm = 32'h12345000;
        id_alu_control = 4'b1010; id_rs1_addr = 1; id_rs1_data = 32'h77; id_pc = 32'h600;
        id_rd_addr = 3; id_reg_write = 1;
        step();
        checks++;
        if (alu_in1 !== 32'h0 || alu_in2 !== 32'h12345000 || alu_control !== 4'b1010) begin
            errors++; $display("FAIL lui got %h %h %h want 0 12345000 a", alu_in1, alu_in2, alu_control);
        end
        id_op_a_sel = 1;
        step();
        checks++;
        if (alu_in1 !== 32'h600) begin
            errors++; $display("FAIL op_a_pc got %h want 600", alu_in1);
        end
        id_op_a_sel = 3;
        step();
        checks++;
        if (alu_in1 !== 32'h0) begin
            errors++; $display("FAIL op_a_sel3 got %h want 0", alu_in1);
        end
        id_valid = 0; id_mem_write = 1;
        step();
        checks++;
        if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_write !== 1'b0) begin
            errors++; $display("FAIL invalid_ctrl got v=%b rw=%b mw=%b want 0 0 0", ex_valid, ex_reg_write, ex_mem_write);
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_x0_guard();
        test_load_use();
        test_stall_flush();
        test_lui();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
